// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: controller state
// encoding and default geometry.
package regfile_pkg;

    localparam int unsigned DEF_BANK_WIDTH     = 5;
    localparam int unsigned DEF_REGISTER_WIDTH = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Bank initialisation controller: sweeps every index writing zero, then
// holds RUN until a clear request restarts the sweep.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned BANK_WIDTH = DEF_BANK_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr_req,
    output logic                  o_clr_we,
    output logic [BANK_WIDTH-1:0] o_clr_idx,
    output logic                  o_ready
);

    state_t                r_state;
    state_t                w_state_next;
    logic [BANK_WIDTH-1:0] r_idx;
    logic [BANK_WIDTH-1:0] w_idx_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // The index wraps to zero on the last clear write, so RUN always starts
    // with a fresh counter for the next sweep.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            CLEAR: begin
                w_idx_next = r_idx + 1'b1;
                if (r_idx == '1) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (i_clr_req) begin
                    w_state_next = CLEAR;
                    w_idx_next   = '0;
                end
            end
            default: begin
                w_state_next = CLEAR;
                w_idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        o_clr_we  = (r_state == CLEAR);
        o_ready   = (r_state == RUN);
        o_clr_idx = r_idx;
    end

endmodule

// File: rtl/register_file_mp.sv
// Two-read / one-write register file with optional hardwired zero register,
// write-to-read forwarding, registered read data and a self-clearing bank.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned BANK_WIDTH      = DEF_BANK_WIDTH,
    parameter int unsigned REGISTER_WIDTH  = DEF_REGISTER_WIDTH,
    parameter int unsigned ZERO_REG        = 1,
    parameter int unsigned BYPASS          = 1,
    parameter int unsigned REGISTERED_READ = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BANK_WIDTH-1:0]     rs1_sel,
    input  logic [BANK_WIDTH-1:0]     rs2_sel,
    output logic [REGISTER_WIDTH-1:0] rs1_data,
    output logic [REGISTER_WIDTH-1:0] rs2_data,
    input  logic [BANK_WIDTH-1:0]     rd_sel,
    input  logic [REGISTER_WIDTH-1:0] rd_data,
    input  logic                      reg_w,
    input  logic                      clr_req,
    output logic                      ready
);

    localparam int unsigned SIZE = 2 ** BANK_WIDTH;

    logic [REGISTER_WIDTH-1:0] r_mem [SIZE];

    logic                      w_clr_we;
    logic [BANK_WIDTH-1:0]     w_clr_idx;
    logic                      w_ready;
    logic                      w_we;
    logic [REGISTER_WIDTH-1:0] w_rs1_val;
    logic [REGISTER_WIDTH-1:0] w_rs2_val;

    regfile_clear_ctrl #(
        .BANK_WIDTH (BANK_WIDTH)
    ) u_clear_ctrl (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_clr_req (clr_req),
        .o_clr_we  (w_clr_we),
        .o_clr_idx (w_clr_idx),
        .o_ready   (w_ready)
    );

    // A write only lands in RUN, without a competing clear, and never to a
    // hardwired zero register.
    always_comb begin
        w_we = w_ready && reg_w && !clr_req &&
               !((ZERO_REG != 0) && (rd_sel == '0));
    end

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_we) begin
            r_mem[rd_sel] <= rd_data;
        end
    end

    function automatic logic [REGISTER_WIDTH-1:0] f_read(
        input logic [BANK_WIDTH-1:0]     sel,
        input logic                      we,
        input logic [BANK_WIDTH-1:0]     wsel,
        input logic [REGISTER_WIDTH-1:0] wdata,
        input logic [REGISTER_WIDTH-1:0] mem_val
    );
        if ((ZERO_REG != 0) && (sel == '0)) begin
            return '0;
        end else if ((BYPASS != 0) && we && (wsel == sel)) begin
            return wdata;
        end
        return mem_val;
    endfunction

    always_comb begin
        w_rs1_val = f_read(rs1_sel, w_we, rd_sel, rd_data, r_mem[rs1_sel]);
        w_rs2_val = f_read(rs2_sel, w_we, rd_sel, rd_data, r_mem[rs2_sel]);
    end

    generate
        if (REGISTERED_READ != 0) begin : g_reg_read
            logic [REGISTER_WIDTH-1:0] r_rs1;
            logic [REGISTER_WIDTH-1:0] r_rs2;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_rs1 <= '0;
                    r_rs2 <= '0;
                end else begin
                    r_rs1 <= w_ready ? w_rs1_val : '0;
                    r_rs2 <= w_ready ? w_rs2_val : '0;
                end
            end

            // Gating keeps outputs zero during the first cycle of a runtime clear.
            always_comb begin
                rs1_data = w_ready ? r_rs1 : '0;
                rs2_data = w_ready ? r_rs2 : '0;
            end
        end else begin : g_comb_read
            always_comb begin
                rs1_data = w_ready ? w_rs1_val : '0;
                rs2_data = w_ready ? w_rs2_val : '0;
            end
        end
    endgenerate

    always_comb begin
        ready = w_ready;
    end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter BANK_WIDTH, default 5, register index width; SIZE = 2**BANK_WIDTH registers.
REQ-002 Parameter REGISTER_WIDTH, default 32, data width per register.
REQ-003 Parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero.
REQ-004 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-005 Parameter REGISTERED_READ, default 0, 0 = combinational read, 1 = read data registered (1-cycle latency).
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 rs1_sel, rs2_sel  input  BANK_WIDTH  read port select.
REQ-009 rs1_data, rs2_data  output  REGISTER_WIDTH  read port data.
REQ-010 rd_sel  input  BANK_WIDTH  write select.
REQ-011 rd_data  input  REGISTER_WIDTH  write data.
REQ-012 reg_w  input  1  write enable, sampled on clk.
REQ-013 clr_req  input  1  runtime request to re-zero the whole bank.
REQ-014 ready  output  1  bank initialised; reads valid, writes accepted.

Function
REQ-015 FSM has two states, CLEAR and RUN, plus index counter idx of BANK_WIDTH bits.
REQ-016 In CLEAR, each cycle writes zero to memory[idx] and increments idx; on idx == SIZE-1 the write completes and the FSM enters RUN, ready = 1 next cycle.
REQ-017 After rst deasserts, ready rises exactly SIZE rising edges later (32 for defaults).
REQ-018 In RUN, clr_req = 1 at a clock edge: idx = 0, state = CLEAR, ready = 0 next cycle; full clear again takes SIZE cycles.
REQ-019 clr_req during CLEAR is ignored; clear continues without restart.
REQ-020 In CLEAR, reg_w is ignored and rs1_data/rs2_data drive all zeros (never X).
REQ-021 In RUN, reg_w = 1 writes rd_data to memory[rd_sel] at the clock edge.
REQ-022 clr_req and reg_w in the same RUN cycle: clear wins, write discarded.
REQ-023 ZERO_REG = 1: writes to index 0 discarded; reads of index 0 return zero regardless of memory content.
REQ-024 BYPASS = 1, REGISTERED_READ = 0: when ready, reg_w = 1, rd_sel == rsX_sel and the index is not a hardwired zero, rsX_data = rd_data in the same cycle.
REQ-025 BYPASS = 0: read in the write cycle returns the old value; new value is visible the next cycle.
REQ-026 REGISTERED_READ = 1: rsX_data reflects rsX_sel sampled at the previous edge; with BYPASS = 1 the sampled value includes the write from that same edge.
REQ-027 Both read ports independent; rs1_sel == rs2_sel returns identical data.

Reset
REQ-028 rst low asynchronously forces state = CLEAR, idx = 0, ready = 0, and registered read outputs to zero.
REQ-029 rst asserted mid-CLEAR or mid-RUN aborts the operation; the clear restarts from idx 0 after release.
REQ-030 Memory array is not reset directly; zeroing happens only through the CLEAR sequence.

Structure
REQ-031 Shared package regfile_pkg holds the state encoding (CLEAR, RUN) and default width constants.
REQ-032 Sub-module regfile_clear_ctrl contains the FSM, idx counter and ready; the top holds the array, write mux, bypass and read logic.

Verification
REQ-033 Reset release, defaults -> ready = 0 for cycles 1..31, 1 at cycle 32; all 32 registers read zero.
REQ-034 Write 0xDEADBEEF to r5, read r5 on rs1 and rs2 next cycle -> both 0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
REQ-035 BYPASS = 1: write 0xA5A5A5A5 to r7 with rs1_sel = 7 in the same cycle -> rs1_data = 0xA5A5A5A5 that cycle; BYPASS = 0 -> old value that cycle.
REQ-036 clr_req with simultaneous write of 0x55 to r3 -> ready low for 32 cycles, then r3 reads 0.
REQ-037 rst pulsed low at clear index 10 -> ready stays 0, full 32-cycle clear after release, all reads zero.
REQ-038 REGISTERED_READ = 1: change rs1_sel from 2 to 4 -> rs1_data updates to r4 content one cycle later.
